// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit feeding the register file write port.
// One radix-2 step per cycle; a fixed latency lets the core simply stall on Busy.
module muldiv_unit #(
  parameter int WORD_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      gclk,
  input  logic                      PowerOn,
  input  logic                      Start,
  input  logic [1:0]                Op,
  input  logic [WORD_WIDTH-1:0]     OperandA,
  input  logic [WORD_WIDTH-1:0]     OperandB,
  input  logic [REG_ADDR_WIDTH-1:0] DestAddr,
  output logic                      Busy,
  output logic                      Done,
  output logic [WORD_WIDTH-1:0]     Result,
  output logic [REG_ADDR_WIDTH-1:0] ResultAddr,
  output logic                      WriteFlag,
  output logic                      DivByZero
);

  localparam int CNT_WIDTH = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WORD_WIDTH);

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateType;

  stateType stateReg, stateNext;
  logic     loadOps, stepEn, finish;

  logic [CNT_WIDTH-1:0]      countReg;
  logic [1:0]                opReg;
  logic [WORD_WIDTH-1:0]     opAReg, opBReg;
  logic [REG_ADDR_WIDTH-1:0] destReg;
  logic                      dbzReg;
  logic [2*WORD_WIDTH-1:0]   prodReg;
  logic [WORD_WIDTH-1:0]     remReg, quoReg;

  logic                      busyReg, doneReg, writeFlagReg, divByZeroReg;
  logic [WORD_WIDTH-1:0]     resultReg;
  logic [REG_ADDR_WIDTH-1:0] resultAddrReg;

  // Datapath step values for the current iteration
  logic [WORD_WIDTH:0]     mulSum;
  logic [2*WORD_WIDTH-1:0] prodStep;
  logic [WORD_WIDTH:0]     divShift, divDiff;
  logic                    divFits;
  logic [WORD_WIDTH-1:0]   remStep, quoStep, resultSel;

  // State register; reset aborts any operation in flight
  always_ff @(posedge gclk) begin
    if (!PowerOn) stateReg <= IDLE;
    else          stateReg <= stateNext;
  end

  // Next-state logic: 16 step cycles, then one cycle to load the result registers
  always_comb begin
    stateNext = stateReg;
    loadOps   = 1'b0;
    stepEn    = 1'b0;
    finish    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (Start) begin
          loadOps   = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (countReg != '0) begin
          stepEn = 1'b1;
        end else begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One shift-add and one restoring-divide step; both run, the op picks the answer
  always_comb begin
    mulSum   = {1'b0, prodReg[2*WORD_WIDTH-1:WORD_WIDTH]}
             + (prodReg[0] ? {1'b0, opAReg} : {(WORD_WIDTH+1){1'b0}});
    prodStep = {mulSum, prodReg[WORD_WIDTH-1:1]};
    divShift = {remReg, quoReg[WORD_WIDTH-1]};
    divDiff  = divShift - {1'b0, opBReg};
    // The partial remainder stays below the divisor, so the borrow bit is a clean sign
    divFits  = ~divDiff[WORD_WIDTH];
    remStep  = divFits ? divDiff[WORD_WIDTH-1:0] : divShift[WORD_WIDTH-1:0];
    quoStep  = {quoReg[WORD_WIDTH-2:0], divFits};
    case (opReg)
      OP_MULLO: resultSel = prodReg[WORD_WIDTH-1:0];
      OP_MULHI: resultSel = prodReg[2*WORD_WIDTH-1:WORD_WIDTH];
      OP_DIVU:  resultSel = dbzReg ? {WORD_WIDTH{1'b1}} : quoReg;
      default:  resultSel = dbzReg ? opAReg : remReg;
    endcase
  end

  // Operand latch, iteration counter and accumulators
  always_ff @(posedge gclk) begin
    if (!PowerOn) begin
      countReg <= '0;
      opReg    <= '0;
      opAReg   <= '0;
      opBReg   <= '0;
      destReg  <= '0;
      dbzReg   <= 1'b0;
      prodReg  <= '0;
      remReg   <= '0;
      quoReg   <= '0;
    end else if (loadOps) begin
      countReg <= CNT_LOAD;
      opReg    <= Op;
      opAReg   <= OperandA;
      opBReg   <= OperandB;
      destReg  <= DestAddr;
      dbzReg   <= Op[1] && (OperandB == '0);
      prodReg  <= {{WORD_WIDTH{1'b0}}, OperandB};
      remReg   <= '0;
      quoReg   <= OperandA;
    end else if (stepEn) begin
      countReg <= countReg - 1'b1;
      prodReg  <= prodStep;
      remReg   <= remStep;
      quoReg   <= quoStep;
    end
  end

  // Registered outputs; Result/ResultAddr hold until the next completion
  always_ff @(posedge gclk) begin
    if (!PowerOn) begin
      busyReg       <= 1'b0;
      doneReg       <= 1'b0;
      writeFlagReg  <= 1'b0;
      divByZeroReg  <= 1'b0;
      resultReg     <= '0;
      resultAddrReg <= '0;
    end else begin
      busyReg      <= (stateNext != IDLE);
      doneReg      <= finish;
      writeFlagReg <= finish;
      divByZeroReg <= finish && dbzReg;
      if (finish) begin
        resultReg     <= resultSel;
        resultAddrReg <= destReg;
      end
    end
  end

  assign Busy       = busyReg;
  assign Done       = doneReg;
  assign WriteFlag  = writeFlagReg;
  assign DivByZero  = divByZeroReg;
  assign Result     = resultReg;
  assign ResultAddr = resultAddrReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        gclk = 1'b0;
  logic        PowerOn;
  logic        Start;
  logic [1:0]  Op;
  logic [15:0] OperandA, OperandB;
  logic [2:0]  DestAddr;
  logic        Busy, Done, WriteFlag, DivByZero;
  logic [15:0] Result;
  logic [2:0]  ResultAddr;

  int checkCount = 0;
  int failCount  = 0;

  muldiv_unit #(.WORD_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
    .gclk       (gclk),
    .PowerOn    (PowerOn),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .DestAddr   (DestAddr),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .ResultAddr (ResultAddr),
    .WriteFlag  (WriteFlag),
    .DivByZero  (DivByZero)
  );

  always #5 gclk = ~gclk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launch one op, wait for Done (bounded), check latency, result and the cycle after
  task automatic runOp(input string name, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] dest,
                       input logic [15:0] expRes, input logic expDbz);
    int cycles;
    bit seen;
    @(negedge gclk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestAddr = dest;
    @(posedge gclk);
    @(negedge gclk);
    // Scramble the operand inputs to confirm they were latched
    Start = 1'b0; OperandA = 16'hDEAD; OperandB = 16'h0000; DestAddr = ~dest; Op = ~op;
    checkValue({name, "_busy_start"}, Busy, 1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge gclk);
      cycles++;
      @(negedge gclk);
      if (Done) seen = 1'b1;
    end
    checkValue({name, "_latency"}, cycles, 17);
    checkValue({name, "_result"}, Result, expRes);
    checkValue({name, "_addr"}, ResultAddr, dest);
    checkValue({name, "_wflag"}, WriteFlag, 1);
    checkValue({name, "_dbz"}, DivByZero, expDbz);
    checkValue({name, "_busy_done"}, Busy, 1);
    @(negedge gclk);
    checkValue({name, "_done_clr"}, {Done, WriteFlag, DivByZero, Busy}, 4'b0000);
    checkValue({name, "_hold"}, {ResultAddr, Result}, {dest, expRes});
    $display("op %-10s op=%0d A=%h B=%h dest=%0d -> Result=%h dbz=%0b latency=%0d",
             name, op, a, b, dest, Result, expDbz, cycles);
  endtask

  initial begin
    int doneCount;
    int doneCycle;
    int wflagCount;

    PowerOn = 1'b0; Start = 1'b1; Op = 2'b00;
    OperandA = 16'h1111; OperandB = 16'h2222; DestAddr = 3'd5;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    checkValue("reset_outputs", {Busy, Done, WriteFlag, DivByZero}, 4'b0000);
    checkValue("reset_result", {ResultAddr, Result}, 19'h0);
    $display("reset held 2 edges: Busy=%0b Done=%0b Result=%h", Busy, Done, Result);

    PowerOn = 1'b1; Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge gclk);
      @(negedge gclk);
      checkValue("idle_quiet", {Busy, Done, WriteFlag, DivByZero, ResultAddr, Result}, 23'h0);
    end
    $display("idle 5 cycles with Start=0: Busy=%0b Result=%h", Busy, Result);

    runOp("mullo",     2'b00, 16'h1234, 16'h0010, 3'd3, 16'h2340, 1'b0);
    runOp("mulhi",     2'b01, 16'h1234, 16'h0010, 3'd3, 16'h0001, 1'b0);
    runOp("mullo_max", 2'b00, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001, 1'b0);
    runOp("mulhi_max", 2'b01, 16'hFFFF, 16'hFFFF, 3'd2, 16'hFFFE, 1'b0);
    runOp("mullo_zero",2'b00, 16'h0000, 16'hFFFF, 3'd4, 16'h0000, 1'b0);
    runOp("divu",      2'b10, 16'd100,  16'd7,    3'd5, 16'h000E, 1'b0);
    runOp("remu",      2'b11, 16'd100,  16'd7,    3'd6, 16'h0002, 1'b0);
    runOp("divu_one",  2'b10, 16'hFFFF, 16'h0001, 3'd7, 16'hFFFF, 1'b0);
    runOp("divu_zero", 2'b10, 16'h1234, 16'h0000, 3'd2, 16'hFFFF, 1'b1);
    runOp("remu_zero", 2'b11, 16'h1234, 16'h0000, 3'd1, 16'h1234, 1'b1);

    // Start pulses during RUN (cycle 5) and during DONE (edge after cycle 17) are ignored
    @(negedge gclk);
    Start = 1'b1; Op = 2'b10; OperandA = 16'd1000; OperandB = 16'd10; DestAddr = 3'd4;
    @(posedge gclk);
    @(negedge gclk);
    Start = 1'b0;
    doneCount = 0;
    doneCycle = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5 || k == 18) begin
        Start = 1'b1; Op = 2'b00; OperandA = 16'h0003; OperandB = 16'h0003; DestAddr = 3'd6;
      end
      @(posedge gclk);
      @(negedge gclk);
      Start = 1'b0;
      if (Done) begin
        doneCount++;
        doneCycle = k;
        checkValue("busy_start_result", {ResultAddr, Result}, {3'd4, 16'd100});
      end
    end
    checkValue("busy_start_done_count", doneCount, 1);
    checkValue("busy_start_done_cycle", doneCycle, 17);
    checkValue("busy_start_idle_after", Busy, 0);
    $display("start-while-busy: dones=%0d at cycle %0d Result=%h", doneCount, doneCycle, Result);

    // Reset during RUN aborts the op without a write
    @(negedge gclk);
    Start = 1'b1; Op = 2'b00; OperandA = 16'h00FF; OperandB = 16'h0101; DestAddr = 3'd7;
    @(posedge gclk);
    @(negedge gclk);
    Start = 1'b0;
    repeat (7) begin
      @(posedge gclk);
      @(negedge gclk);
    end
    checkValue("abort_busy_before", Busy, 1);
    PowerOn = 1'b0;
    @(posedge gclk);
    @(negedge gclk);
    PowerOn = 1'b1;
    checkValue("abort_busy_after", {Busy, Done, WriteFlag}, 3'b000);
    wflagCount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge gclk);
      @(negedge gclk);
      if (WriteFlag || Done) wflagCount++;
    end
    checkValue("abort_no_write", wflagCount, 0);
    checkValue("abort_idle", Busy, 0);
    $display("reset mid-run: Busy=%0b writes seen=%0d", Busy, wflagCount);

    runOp("after_abort", 2'b11, 16'd1000, 16'd33, 3'd3, 16'd10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
